// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the imem address and pairs each returned word with its PC.
// Latency: a word appears the cycle after its address is issued; one instruction per cycle sustained.
// Backpressure: stall with a valid output freezes the output and re-reads the same word; redirect overrides.
module inst_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PC_STEP    = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  hold;
    logic                  handoff;

    // Stall only bites once something is on display, so the pipe can fill.
    assign hold    = stall & instr_valid;
    assign handoff = instr_valid & ~stall;

    assign mem_wren = 1'b0;
    assign mem_data = '0;
    assign instr    = mem_q;

    // Holding re-reads instr_pc so mem_q keeps showing the same word.
    always_comb begin
        mem_address = fetch_pc;
        if (reset)
            mem_address = RESET_PC;
        else if (redirect)
            mem_address = redirect_addr;
        else if (hold)
            mem_address = instr_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (handoff)
                fetch_count <= fetch_count + 32'd1;
            if (redirect) begin
                instr_pc    <= redirect_addr;
                instr_valid <= 1'b1;
                fetch_pc    <= redirect_addr + STEP;
            end else if (!hold) begin
                instr_pc    <= fetch_pc;
                instr_valid <= 1'b1;
                fetch_pc    <= fetch_pc + STEP;
            end
        end
    end

endmodule
